// File: rtl/cpu15_pkg.sv
// cpu15 shared definitions: sequencer state indices, PHASE codes and the
// one-hot state type used by stage_seq.
package cpu15_pkg;

    localparam int NSTATE = 6;

    // Bit position of each state inside the one-hot state register.
    localparam int S_IDLE   = 0;
    localparam int S_FT     = 1;
    localparam int S_DC     = 2;
    localparam int S_EX     = 3;
    localparam int S_WB     = 4;
    localparam int S_HALTED = 5;

    // Externally visible PHASE codes.
    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_FT     = 3'd1;
    localparam logic [2:0] PH_DC     = 3'd2;
    localparam logic [2:0] PH_EX     = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;
    localparam logic [2:0] PH_HALTED = 3'd5;

    typedef enum logic [NSTATE-1:0] {
        ST_IDLE   = 6'b000001,
        ST_FT     = 6'b000010,
        ST_DC     = 6'b000100,
        ST_EX     = 6'b001000,
        ST_WB     = 6'b010000,
        ST_HALTED = 6'b100000
    } state_e;

endpackage

// File: rtl/stage_seq.sv
// Instruction-phase sequencer: rotates one-hot FT/DC/EX/WB strobes, handles
// run / step / stop / stall / halt control and counts retired instructions.
module stage_seq #(
    parameter int CNT_W        = 16,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             RUN,
    input  logic             STEP,
    input  logic             STOP,
    input  logic             STALL,
    input  logic             HALT_REQ,
    output logic             CLK_FT,
    output logic             CLK_DC,
    output logic             CLK_EX,
    output logic             CLK_WB,
    output logic [2:0]       PHASE,
    output logic             RUNNING,
    output logic             HALTED,
    output logic [CNT_W-1:0] INSTR_CNT
);
    import cpu15_pkg::*;

    state_e           state_q, state_d;
    logic             stop_q, stop_d;
    logic             single_q, single_d;
    logic             auto_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go;
    logic             retire;

    // Next-state, stop latch, single-step flag and retire decision.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        state_d  = state_q;
        stop_d   = stop_q;
        single_d = single_q;
        retire   = 1'b0;
        go       = RUN | (RUN_ON_RESET & auto_q);
        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (go) begin
                    state_d  = ST_FT;
                    single_d = 1'b0;
                end else if (STEP) begin
                    state_d  = ST_FT;
                    single_d = 1'b1;
                end
            end
            ST_FT: begin
                stop_d = stop_q | STOP;
                if (!STALL) state_d = ST_DC;
            end
            ST_DC: begin
                stop_d = stop_q | STOP;
                if (!STALL) state_d = ST_EX;
            end
            ST_EX: begin
                stop_d = stop_q | STOP;
                if (!STALL) state_d = ST_WB;
            end
            ST_WB: begin
                stop_d = stop_q | STOP;
                if (!STALL) begin
                    retire = 1'b1;
                    if (HALT_REQ) begin
                        state_d = ST_HALTED;
                        stop_d  = 1'b0;
                    end else if (stop_q | STOP | single_q) begin
                        state_d = ST_IDLE;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = ST_FT;
                    end
                end
            end
            ST_HALTED: begin
                stop_d = 1'b0;
                if (RUN) begin
                    state_d  = ST_FT;
                    single_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stop_d  = 1'b0;
            end
        endcase
        cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Sequencer state and control latches; RESET wins over everything.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RESET) begin
            state_q  <= ST_IDLE;
            stop_q   <= 1'b0;
            single_q <= 1'b0;
            auto_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            stop_q   <= stop_d;
            single_q <= single_d;
            auto_q   <= 1'b0;
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Strobes come straight from the state flops so they cannot glitch.
    assign CLK_FT    = state_q[S_FT];
    assign CLK_DC    = state_q[S_DC];
    assign CLK_EX    = state_q[S_EX];
    assign CLK_WB    = state_q[S_WB];
    assign RUNNING   = state_q[S_FT] | state_q[S_DC] | state_q[S_EX] | state_q[S_WB];
    assign HALTED    = state_q[S_HALTED];
    assign INSTR_CNT = cnt_q;

    // Decode the one-hot state into the numeric PHASE code.
    always_comb begin
        PHASE = PH_IDLE;
        case (state_q)
            ST_FT:     PHASE = PH_FT;
            ST_DC:     PHASE = PH_DC;
            ST_EX:     PHASE = PH_EX;
            ST_WB:     PHASE = PH_WB;
            ST_HALTED: PHASE = PH_HALTED;
            default:   PHASE = PH_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stage_seq.sv
// Self-checking bench for stage_seq: a behavioural phase model compared every
// cycle, plus directed literal checks. A second instance (CNT_W=2,
// RUN_ON_RESET=1) free-runs to exercise auto-start and counter wrap.
module tb_stage_seq;

    logic clk;
    logic rst, run, step, stop, stall, halt;
    logic rst2;

    logic        ft1, dc1, ex1, wb1, running1, halted1;
    logic [2:0]  phase1;
    logic [15:0] cnt1;
    logic        ft2, dc2, ex2, wb2, running2, halted2;
    logic [2:0]  phase2;
    logic [1:0]  cnt2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    stage_seq #(.CNT_W(16), .RUN_ON_RESET(1'b0)) dut (
        .CLK(clk), .RESET(rst), .RUN(run), .STEP(step), .STOP(stop),
        .STALL(stall), .HALT_REQ(halt),
        .CLK_FT(ft1), .CLK_DC(dc1), .CLK_EX(ex1), .CLK_WB(wb1),
        .PHASE(phase1), .RUNNING(running1), .HALTED(halted1), .INSTR_CNT(cnt1)
    );

    stage_seq #(.CNT_W(2), .RUN_ON_RESET(1'b1)) dut2 (
        .CLK(clk), .RESET(rst2), .RUN(1'b0), .STEP(1'b0), .STOP(1'b0),
        .STALL(1'b0), .HALT_REQ(1'b0),
        .CLK_FT(ft2), .CLK_DC(dc2), .CLK_EX(ex2), .CLK_WB(wb2),
        .PHASE(phase2), .RUNNING(running2), .HALTED(halted2), .INSTR_CNT(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase number 0 idle, 1..4 FT..WB, 5 halted; plain retire count.
    typedef struct {
        int          ph;
        int unsigned cnt;
        bit          stop_l;
        bit          single;
        bit          first;
    } model_t;

    model_t m1, m2;

    task automatic model_step(inout model_t m, input bit r, input bit rn,
                              input bit st, input bit sp, input bit sl,
                              input bit hq, input bit auto_run);
        bit first_now;
        if (r) begin
            m.ph = 0; m.cnt = 0; m.stop_l = 0; m.single = 0; m.first = 1;
            return;
        end
        first_now = m.first;
        m.first   = 0;
        if (m.ph == 0) begin
            m.stop_l = 0;
            if (rn || (auto_run && first_now)) begin m.ph = 1; m.single = 0; end
            else if (st) begin m.ph = 1; m.single = 1; end
        end else if (m.ph == 5) begin
            if (rn) begin m.ph = 1; m.single = 0; end
        end else begin
            if (sp) m.stop_l = 1;
            if (!sl) begin
                if (m.ph < 4) m.ph = m.ph + 1;
                else begin
                    m.cnt = m.cnt + 1;
                    if (hq)                       begin m.ph = 5; m.stop_l = 0; end
                    else if (m.stop_l || m.single) begin m.ph = 0; m.stop_l = 0; end
                    else                           m.ph = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(m1, rst,  run,  step, stop, stall, halt, 1'b0);
        model_step(m2, rst2, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic ft, input logic dc, input logic ex,
                                         input logic wb, input logic [2:0] ph,
                                         input logic rn, input logic hl, input logic [15:0] c);
        return {7'd0, ft, dc, ex, wb, ph, rn, hl, c};
    endfunction

    function automatic logic [31:0] expect_of(input model_t m, input int unsigned mask);
        return pack(m.ph == 1, m.ph == 2, m.ph == 3, m.ph == 4, 3'(m.ph),
                    (m.ph >= 1 && m.ph <= 4), m.ph == 5, 16'(m.cnt & mask));
    endfunction

    // Per-cycle compare of both instances against the model, away from posedge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model1", pack(ft1, dc1, ex1, wb1, phase1, running1, halted1, cnt1),
                  expect_of(m1, 32'hFFFF));
            check("model2", pack(ft2, dc2, ex2, wb2, phase2, running2, halted2, {14'd0, cnt2}),
                  expect_of(m2, 32'h3));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1; rst2 = 1; run = 0; step = 0; stop = 0; stall = 0; halt = 0;
        cyc(2);
        chk_en = 1;
        check("reset_phase", {29'd0, phase1}, 32'd0);
        check("reset_cnt",   {16'd0, cnt1},   32'd0);
        check("reset_strb",  {28'd0, ft1, dc1, ex1, wb1}, 32'd0);
        rst = 0; rst2 = 0;
        cyc(1);
        check("idle_no_auto", {29'd0, phase1}, 32'd0);
        check("auto_run_ft",  {29'd0, phase2}, 32'd1);
        run = 1;
        cyc(1);
        run = 0;
        check("run_ft", {31'd0, ft1}, 32'd1);
        cyc(12);
        check("run_cnt3",   {16'd0, cnt1}, 32'd3);
        check("run_ph_ft",  {29'd0, phase1}, 32'd1);
        check("dut2_cnt3",  {30'd0, cnt2}, 32'd3);
        cyc(4);
        check("dut2_wrap",  {30'd0, cnt2}, 32'd0);
        check("run_cnt4",   {16'd0, cnt1}, 32'd4);
        // STOP pulsed in FT: finish this instruction, then IDLE.
        stop = 1;
        cyc(1);
        stop = 0;
        cyc(3);
        check("stop_idle", {29'd0, phase1}, 32'd0);
        check("stop_cnt",  {16'd0, cnt1}, 32'd5);
        // STOP with RUN in IDLE: latch stays clear, run continues.
        stop = 1; run = 1;
        cyc(1);
        stop = 0; run = 0;
        cyc(4);
        check("stoprun_ft",  {29'd0, phase1}, 32'd1);
        check("stoprun_cnt", {16'd0, cnt1}, 32'd6);
        // STALL three cycles in DC: DC strobe held four cycles, then EX.
        cyc(1);
        check("stall_dc0", {31'd0, dc1}, 32'd1);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            check("stall_dc", {28'd0, ft1, dc1, ex1, wb1}, 32'b0100);
        end
        stall = 0;
        cyc(1);
        check("stall_ex", {31'd0, ex1}, 32'd1);
        // HALT_REQ through EX/WB.
        halt = 1;
        cyc(2);
        halt = 0;
        check("halt_state", {29'd0, phase1}, 32'd5);
        check("halt_flag",  {31'd0, halted1}, 32'd1);
        check("halt_cnt",   {16'd0, cnt1}, 32'd7);
        check("halt_strb",  {28'd0, ft1, dc1, ex1, wb1}, 32'd0);
        step = 1;
        cyc(1);
        check("halt_step_ign", {29'd0, phase1}, 32'd5);
        run = 1;
        cyc(1);
        run = 0; step = 0;
        check("resume_ft", {29'd0, phase1}, 32'd1);
        stop = 1;
        cyc(1);
        stop = 0;
        cyc(3);
        check("stop2_idle", {29'd0, phase1}, 32'd0);
        check("stop2_cnt",  {16'd0, cnt1}, 32'd8);
        // Single step twice.
        step = 1;
        cyc(1);
        step = 0;
        check("step_ft", {29'd0, phase1}, 32'd1);
        cyc(4);
        check("step1_idle", {29'd0, phase1}, 32'd0);
        check("step1_cnt",  {16'd0, cnt1}, 32'd9);
        step = 1;
        cyc(1);
        step = 0;
        cyc(4);
        check("step2_cnt", {16'd0, cnt1}, 32'd10);
        // RUN and STEP together: run wins, keeps rotating.
        run = 1; step = 1;
        cyc(1);
        run = 0; step = 0;
        cyc(8);
        check("runstep_ft",  {29'd0, phase1}, 32'd1);
        check("runstep_cnt", {16'd0, cnt1}, 32'd12);
        // Reset during EX.
        cyc(2);
        check("pre_rst_ex", {31'd0, ex1}, 32'd1);
        rst = 1;
        cyc(1);
        rst = 0;
        check("rst_ex_idle", {29'd0, phase1}, 32'd0);
        check("rst_ex_cnt",  {16'd0, cnt1}, 32'd0);
        cyc(3);
        check("rst_stay_idle", {29'd0, phase1}, 32'd0);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
